// File: rtl/cell_axilite_arbiter.sv
// cell_axilite_arbiter: round-robin arbiter funnelling two requesters onto one AXI-lite master, one transaction at a time
module cell_axilite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata_in,
  input  logic [2*SW-1:0]         wstrb_in,
  output logic [1:0]              done,
  output logic [DATA_WIDTH-1:0]   rdata_out,
  output logic [1:0]              resp_out,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [SW-1:0]           wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_t;
  state_t state, nxt;
  logic grant, last, pick, aw_pend, w_pend;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [SW-1:0] wstrb_q;
  logic [1:0] resp_q;
  assign pick = &req ? ~last : req[1];
  always_comb begin
    nxt = state;
    awvalid = state == WRITE && aw_pend;
    wvalid = state == WRITE && w_pend;
    bready = state == WRESP;
    arvalid = state == RADDR;
    rready = state == RDATA;
    busy = state != IDLE;
    done = state == DONE ? {grant, ~grant} : 2'b00;
    rdata_out = state == DONE ? rdata_q : '0;
    resp_out = state == DONE ? resp_q : 2'b00;
    awaddr = addr_q;
    araddr = addr_q;
    wdata = wdata_q;
    wstrb = wstrb_q;
    case (state)
      IDLE:    nxt = |req ? (we[pick] ? WRITE : RADDR) : IDLE;
      WRITE:   nxt = (!aw_pend || awready) && (!w_pend || wready) ? WRESP : WRITE;
      WRESP:   nxt = bvalid ? DONE : WRESP;
      RADDR:   nxt = arready ? RDATA : RADDR;
      RDATA:   nxt = rvalid ? DONE : RDATA;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      grant <= 1'b0;
      last <= 1'b1;
      aw_pend <= 1'b0;
      w_pend <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q <= 2'b00;
    end else begin
      state <= nxt;
      if (state == IDLE && |req) begin
        grant <= pick;
        last <= pick;
        addr_q <= pick ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
        wdata_q <= pick ? wdata_in[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_in[DATA_WIDTH-1:0];
        wstrb_q <= pick ? wstrb_in[2*SW-1:SW] : wstrb_in[SW-1:0];
        aw_pend <= we[pick];
        w_pend <= we[pick];
      end
      if (awvalid && awready) aw_pend <= 1'b0;
      if (wvalid && wready) w_pend <= 1'b0;
      if (state == WRESP && bvalid) begin
        resp_q <= bresp;
        rdata_q <= '0;
      end
      if (state == RDATA && rvalid) begin
        resp_q <= rresp;
        rdata_q <= rdata;
      end
    end
endmodule

// File: tb/tb_cell_axilite_arbiter.sv
// tb_cell_axilite_arbiter: directed scoreboard bench for the two-requester AXI-lite arbiter
module tb_cell_axilite_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [1:0] req = '0, we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata_in = '0;
  logic [2*SW-1:0] wstrb_in = '0;
  logic [1:0] done, resp_out, bresp, rresp;
  logic [DW-1:0] rdata_out, wdata, rdata;
  logic [AW-1:0] awaddr, araddr;
  logic [SW-1:0] wstrb;
  logic busy, awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;

  cell_axilite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .we(we), .addr(addr),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .done(done), .rdata_out(rdata_out),
    .resp_out(resp_out), .busy(busy), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [1:0] done; logic [DW-1:0] rdata; logic [1:0] resp; } done_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] wstrb; } axi_t;
  done_t exp_done[$];
  axi_t exp_axi[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // slave model: readiness comes from per-channel wait counts; handshakes are
  // sampled on the falling edge and applied to slave state on the rising edge
  int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0] b_code = 2'b00, r_code = 2'b00;
  logic [DW-1:0] r_word = '0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, aw_act = 0, w_act = 0, ar_act = 0;
  logic aw_seen = 0, w_seen = 0;
  int ar_run = 0, ar_len = 0, b_count = 0;

  assign awready = awvalid && aw_cnt >= aw_wait;
  assign wready = wvalid && w_cnt >= w_wait;
  assign arready = arvalid && ar_cnt >= ar_wait;
  assign bvalid = b_pend;
  assign bresp = b_code;
  assign rvalid = r_pend && r_cnt >= r_wait;
  assign rresp = r_code;
  assign rdata = r_word;

  always @(posedge aclk) cyc++;

  always @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
    end else begin
      aw_cnt <= aw_act && !aw_hs ? aw_cnt + 1 : 0;
      w_cnt <= w_act && !w_hs ? w_cnt + 1 : 0;
      ar_cnt <= ar_act && !ar_hs ? ar_cnt + 1 : 0;
      r_cnt <= r_pend && !r_hs ? r_cnt + 1 : 0;
      aw_got <= (aw_got || aw_hs) && !(w_got || w_hs);
      w_got <= (w_got || w_hs) && !(aw_got || aw_hs);
      b_pend <= b_hs ? 1'b0 : (b_pend || ((aw_got || aw_hs) && (w_got || w_hs)));
      r_pend <= r_hs ? 1'b0 : (r_pend || ar_hs);
    end

  // monitor: checks every AXI request against the expected-transaction queue
  // and every done pulse against the expected-completion queue
  always @(negedge aclk) begin
    done_t e;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    b_hs = bvalid && bready;
    ar_hs = arvalid && arready;
    r_hs = rvalid && rready;
    aw_act = awvalid;
    w_act = wvalid;
    ar_act = arvalid;
    if (!aresetn) begin
      aw_seen = 0; w_seen = 0; ar_run = 0;
    end
    if (arvalid) ar_run++;
    if (ar_hs) begin
      ar_len = ar_run;
      ar_run = 0;
    end
    if (b_hs) b_count++;
    if (aw_hs) begin
      check("aw_expected", exp_axi.size() != 0 && exp_axi[0].we, 1);
      if (exp_axi.size() != 0) check("awaddr", awaddr, exp_axi[0].addr);
      aw_seen = 1;
    end
    if (w_hs) begin
      check("w_expected", exp_axi.size() != 0 && exp_axi[0].we, 1);
      if (exp_axi.size() != 0) begin
        check("wdata", wdata, exp_axi[0].wdata);
        check("wstrb", wstrb, exp_axi[0].wstrb);
      end
      w_seen = 1;
    end
    if (aw_seen && w_seen) begin
      aw_seen = 0;
      w_seen = 0;
      if (exp_axi.size() != 0) void'(exp_axi.pop_front());
    end
    if (ar_hs) begin
      check("ar_expected", exp_axi.size() != 0 && !exp_axi[0].we, 1);
      if (exp_axi.size() != 0) begin
        check("araddr", araddr, exp_axi[0].addr);
        void'(exp_axi.pop_front());
      end
    end
    if (done != 2'b00) begin
      check("done_onehot", $onehot(done), 1);
      check("done_expected", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) begin
        e = exp_done.pop_front();
        check("done_idx", done, e.done);
        check("rdata_out", rdata_out, e.rdata);
        check("resp_out", resp_out, e.resp);
      end
    end
  end

  function automatic axi_t mk_axi(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    axi_t t;
    t.we = w; t.addr = a; t.wdata = d; t.wstrb = s;
    return t;
  endfunction

  function automatic done_t mk_done(input logic [1:0] m, input logic [DW-1:0] r, input logic [1:0] p);
    done_t t;
    t.done = m; t.rdata = r; t.resp = p;
    return t;
  endfunction

  task automatic txn(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input logic [DW-1:0] exp_rd, input logic [1:0] exp_resp,
                     output int lat);
    int start;
    @(posedge aclk); #1;
    req[i] = 1'b1;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata_in[i*DW +: DW] = d;
    wstrb_in[i*SW +: SW] = s;
    exp_axi.push_back(mk_axi(w, a, d, s));
    exp_done.push_back(mk_done(i == 0 ? 2'b01 : 2'b10, w ? '0 : exp_rd, exp_resp));
    start = cyc;
    for (int n = 0; n < 60 && !done[i]; n++) @(negedge aclk);
    check("txn_done_seen", done[i], 1);
    lat = cyc - start;
    req[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, k, b0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_rdata_out", rdata_out, 0);
    check("rst_resp_out", resp_out, 0);
    aresetn = 1'b1;

    // single write from requester 0, zero-wait slave
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, '0, 2'b00, lat);
    check("wr_latency", lat, 3);

    // read from requester 1 with arready held back
    ar_wait = 2;
    r_word = 32'h12345678;
    txn(1, 1'b0, 32'h20, '0, '0, 32'h12345678, 2'b00, lat);
    check("ar_held_cycles", ar_len, 3);
    ar_wait = 0;

    // both requesters held: last grant was 1, so order is 0,1,0,1
    r_word = 32'hA5A50001;
    @(posedge aclk); #1;
    req = 2'b11;
    we = 2'b01;
    addr = {32'h104, 32'h100};
    wdata_in = {32'h0, 32'hCAFE0000};
    wstrb_in = {4'h0, 4'h3};
    for (int n = 0; n < 4; n++)
      if (n % 2 == 0) begin
        exp_axi.push_back(mk_axi(1'b1, 32'h100, 32'hCAFE0000, 4'h3));
        exp_done.push_back(mk_done(2'b01, '0, 2'b00));
      end else begin
        exp_axi.push_back(mk_axi(1'b0, 32'h104, '0, '0));
        exp_done.push_back(mk_done(2'b10, 32'hA5A50001, 2'b00));
      end
    k = 0;
    for (int n = 0; n < 100 && k < 4; n++) begin
      @(negedge aclk);
      if (done != 2'b00) k++;
    end
    check("rr_done_count", k, 4);
    req = 2'b00;
    we = 2'b00;

    // wready two cycles ahead of awready
    aw_wait = 2;
    b0 = b_count;
    fork
      txn(0, 1'b1, 32'h30, 32'h11223344, 4'hC, '0, 2'b00, lat);
      begin
        @(posedge aclk); #1;
        repeat (3) @(negedge aclk);
        check("aw_held_w_dropped", {awvalid, wvalid}, 2'b10);
      end
    join
    check("b_accepted_once", b_count - b0, 1);
    aw_wait = 0;

    // SLVERR passes through with no retry
    b_code = 2'b10;
    txn(1, 1'b1, 32'h40, 32'h55, 4'hF, '0, 2'b10, lat);
    b_code = 2'b00;
    repeat (5) @(negedge aclk);
    check("no_retry_busy", busy, 0);
    check("no_retry_axi_queue", exp_axi.size(), 0);

    // reset while waiting in RDATA abandons the read
    r_wait = 5;
    @(posedge aclk); #1;
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[AW +: AW] = 32'h50;
    exp_axi.push_back(mk_axi(1'b0, 32'h50, '0, '0));
    @(posedge aclk); #1;
    req[1] = 1'b0;
    @(posedge aclk); #1;
    check("in_rdata_rready", rready, 1);
    aresetn = 1'b0;
    #1;
    check("abort_valids", {arvalid, rready, bready, awvalid, wvalid}, 5'b0);
    check("abort_done", done, 2'b00);
    check("abort_busy", busy, 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    r_wait = 0;
    r_word = 32'h0BADF00D;
    txn(1, 1'b0, 32'h60, '0, '0, 32'h0BADF00D, 2'b00, lat);
    check("rd_latency", lat, 3);

    repeat (3) @(negedge aclk);
    check("exp_done_empty", exp_done.size(), 0);
    check("exp_axi_empty", exp_axi.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
